// File: rtl/cues_pkg.sv
// Shared constants for the sSB match path: field widths, mem_wen encodings and
// the match-stage FSM state type.
package cues_pkg;

  localparam int NODE_W = 16;
  localparam int GEN_W  = 12;
  localparam int OPR_W  = 32;
  localparam int KEY_W  = NODE_W + GEN_W;

  localparam logic [1:0] MW_BYP   = 2'b00;
  localparam logic [1:0] MW_L     = 2'b01;
  localparam logic [1:0] MW_R     = 2'b10;
  localparam logic [1:0] MW_PURGE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOOK = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/ssm_match_tbl.sv
// Direct-mapped operand match table: flop storage, one compare/read port and
// one write/clear port sharing the same cycle.
module ssm_match_tbl
  import cues_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [KEY_W-1:0] rd_key_i,
  input  logic             rd_side_i,
  output logic             hit_o,
  output logic             empty_o,
  output logic             conflict_o,
  output logic             key_eq_o,
  output logic [OPR_W-1:0] rd_opr_o,
  input  logic             wr_en_i,
  input  logic             clr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_side_i,
  input  logic [KEY_W-1:0] wr_key_i,
  input  logic [OPR_W-1:0] wr_opr_i
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [DEPTH-1:0] v_q;
  logic             side_q [DEPTH];
  logic [KEY_W-1:0] key_q  [DEPTH];
  logic [OPR_W-1:0] opr_q  [DEPTH];

  // Only valid bits need clearing; payload is qualified by them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
    end else if (wr_en_i) begin
      v_q[wr_idx_i] <= 1'b1;
    end else if (clr_en_i) begin
      v_q[wr_idx_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      side_q[wr_idx_i] <= wr_side_i;
      key_q[wr_idx_i]  <= wr_key_i;
      opr_q[wr_idx_i]  <= wr_opr_i;
    end
  end

  always_comb begin
    empty_o    = !v_q[rd_idx_i];
    key_eq_o   = v_q[rd_idx_i] && (key_q[rd_idx_i] == rd_key_i);
    hit_o      = key_eq_o && (side_q[rd_idx_i] != rd_side_i);
    conflict_o = v_q[rd_idx_i] && !hit_o;
    rd_opr_o   = opr_q[rd_idx_i];
  end

endmodule

// File: rtl/ssm_match.sv
// Operand matching stage: parks the first operand of a node+gen pair and emits
// a paired token when its partner arrives; bypass, purge and conflict tokens too.
module ssm_match
  import cues_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_send_i_smm,
  output logic              in_ack_o_smm,
  input  logic [NODE_W-1:0] node_i_smm,
  input  logic [GEN_W-1:0]  gen_i_smm,
  input  logic [OPR_W-1:0]  opr_i_smm,
  input  logic [1:0]        mem_wen_i_smm,
  output logic              out_send_o_smm,
  input  logic              out_ack_i_smm,
  output logic [NODE_W-1:0] node_o_smm,
  output logic [GEN_W-1:0]  gen_o_smm,
  output logic [OPR_W-1:0]  opr_l_o_smm,
  output logic [OPR_W-1:0]  opr_r_o_smm,
  output logic              pair_o_smm,
  output logic              ovf_o_smm,
  output logic [IDX_W:0]    occ_o_smm
);

  localparam logic [IDX_W:0] OCC_ONE = 1;

  state_e state_q, state_d;
  logic [NODE_W-1:0] node_q;
  logic [GEN_W-1:0]  gen_q;
  logic [OPR_W-1:0]  opr_q;
  logic [1:0]        mw_q;
  logic              tok_ld;

  logic              out_send_q, out_send_d;
  logic [NODE_W-1:0] node_o_q, node_o_d;
  logic [GEN_W-1:0]  gen_o_q, gen_o_d;
  logic [OPR_W-1:0]  opr_l_q, opr_l_d, opr_r_q, opr_r_d;
  logic              pair_q, pair_d, ovf_q, ovf_d;
  logic [IDX_W:0]    occ_q, occ_d;

  logic              emit, is_pair, is_ovf, wr_en, clr_en;
  logic              tbl_hit, tbl_empty, tbl_conflict, tbl_key_eq;
  logic [OPR_W-1:0]  tbl_opr;
  logic [IDX_W-1:0]  idx;

  assign idx = node_q[IDX_W-1:0] ^ gen_q[IDX_W-1:0];

  ssm_match_tbl #(.IDX_W(IDX_W)) u_tbl (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (idx),
    .rd_key_i   ({node_q, gen_q}),
    .rd_side_i  (mw_q[1]),
    .hit_o      (tbl_hit),
    .empty_o    (tbl_empty),
    .conflict_o (tbl_conflict),
    .key_eq_o   (tbl_key_eq),
    .rd_opr_o   (tbl_opr),
    .wr_en_i    (wr_en),
    .clr_en_i   (clr_en),
    .wr_idx_i   (idx),
    .wr_side_i  (mw_q[1]),
    .wr_key_i   ({node_q, gen_q}),
    .wr_opr_i   (opr_q)
  );

  // Ready is forced low while reset is held.
  assign in_ack_o_smm = rst && (state_q == ST_IDLE);

  always_comb begin
    state_d    = state_q;
    tok_ld     = 1'b0;
    wr_en      = 1'b0;
    clr_en     = 1'b0;
    emit       = 1'b0;
    is_pair    = 1'b0;
    is_ovf     = 1'b0;
    occ_d      = occ_q;
    out_send_d = out_send_q;
    node_o_d   = node_o_q;
    gen_o_d    = gen_o_q;
    opr_l_d    = opr_l_q;
    opr_r_d    = opr_r_q;
    pair_d     = pair_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_send_i_smm) begin
          tok_ld  = 1'b1;
          state_d = ST_LOOK;
        end
      end
      ST_LOOK: begin
        unique case (mw_q)
          MW_BYP: emit = 1'b1;
          MW_L, MW_R: begin
            if (tbl_empty) begin
              wr_en = 1'b1;
              occ_d = occ_q + OCC_ONE;
            end else if (tbl_hit) begin
              clr_en  = 1'b1;
              occ_d   = occ_q - OCC_ONE;
              emit    = 1'b1;
              is_pair = 1'b1;
            end else if (tbl_conflict) begin
              emit   = 1'b1;
              is_ovf = 1'b1;
            end
          end
          default: begin
            if (tbl_key_eq) begin
              clr_en = 1'b1;
              occ_d  = occ_q - OCC_ONE;
            end
          end
        endcase
        state_d = emit ? ST_OUT : ST_IDLE;
        if (emit) begin
          out_send_d = 1'b1;
          node_o_d   = node_q;
          gen_o_d    = gen_q;
          // Left/right placement follows the token's side, not arrival order.
          opr_l_d    = (is_pair && mw_q == MW_R) ? tbl_opr : opr_q;
          opr_r_d    = !is_pair ? '0 : ((mw_q == MW_R) ? opr_q : tbl_opr);
          pair_d     = is_pair;
          ovf_d      = is_ovf;
        end
      end
      default: begin
        if (out_ack_i_smm) begin
          out_send_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      node_q     <= '0;
      gen_q      <= '0;
      opr_q      <= '0;
      mw_q       <= '0;
      out_send_q <= 1'b0;
      node_o_q   <= '0;
      gen_o_q    <= '0;
      opr_l_q    <= '0;
      opr_r_q    <= '0;
      pair_q     <= 1'b0;
      ovf_q      <= 1'b0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      if (tok_ld) begin
        node_q <= node_i_smm;
        gen_q  <= gen_i_smm;
        opr_q  <= opr_i_smm;
        mw_q   <= mem_wen_i_smm;
      end
      out_send_q <= out_send_d;
      node_o_q   <= node_o_d;
      gen_o_q    <= gen_o_d;
      opr_l_q    <= opr_l_d;
      opr_r_q    <= opr_r_d;
      pair_q     <= pair_d;
      ovf_q      <= ovf_d;
      occ_q      <= occ_d;
    end
  end

  assign out_send_o_smm = out_send_q;
  assign node_o_smm     = node_o_q;
  assign gen_o_smm      = gen_o_q;
  assign opr_l_o_smm    = opr_l_q;
  assign opr_r_o_smm    = opr_r_q;
  assign pair_o_smm     = pair_q;
  assign ovf_o_smm      = ovf_q;
  assign occ_o_smm      = occ_q;

endmodule

// File: tb/tb_ssm_match.sv
// Randomized scoreboard bench for ssm_match against a table-level reference model.
module tb_ssm_match;
  import cues_pkg::*;

  localparam int IDX_W = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_send = 1'b0, in_ack;
  logic [NODE_W-1:0] node_i = '0;
  logic [GEN_W-1:0]  gen_i = '0;
  logic [OPR_W-1:0]  opr_i = '0;
  logic [1:0]        mw_i = '0;
  logic out_send, out_ack = 1'b0;
  logic [NODE_W-1:0] node_o;
  logic [GEN_W-1:0]  gen_o;
  logic [OPR_W-1:0]  opr_l, opr_r;
  logic pair_o, ovf_o;
  logic [IDX_W:0] occ;

  always #5 clk = ~clk;

  ssm_match #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .in_send_i_smm(in_send), .in_ack_o_smm(in_ack),
    .node_i_smm(node_i), .gen_i_smm(gen_i), .opr_i_smm(opr_i), .mem_wen_i_smm(mw_i),
    .out_send_o_smm(out_send), .out_ack_i_smm(out_ack),
    .node_o_smm(node_o), .gen_o_smm(gen_o),
    .opr_l_o_smm(opr_l), .opr_r_o_smm(opr_r),
    .pair_o_smm(pair_o), .ovf_o_smm(ovf_o), .occ_o_smm(occ)
  );

  typedef struct packed {
    logic [NODE_W-1:0] node;
    logic [GEN_W-1:0]  gen;
    logic [OPR_W-1:0]  l;
    logic [OPR_W-1:0]  r;
    logic              pair;
    logic              ovf;
  } tok_t;

  tok_t exp_q[$];
  int checks = 0;
  int failures = 0;
  bit stall = 1'b0;

  // Reference table: slot index is node^gen folded to DEPTH entries.
  bit                mv   [DEPTH];
  int                mside[DEPTH];
  logic [KEY_W-1:0]  mkey [DEPTH];
  logic [OPR_W-1:0]  mopr [DEPTH];
  int                mocc = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
    mocc = 0;
    exp_q.delete();
  endfunction

  function automatic void model_accept(logic [NODE_W-1:0] n, logic [GEN_W-1:0] g,
                                       logic [OPR_W-1:0] o, logic [1:0] mw);
    int i;
    logic [KEY_W-1:0] k;
    i = (int'(n) ^ int'(g)) % DEPTH;
    k = {n, g};
    if (mw == 2'd0) begin
      exp_q.push_back({n, g, o, 32'd0, 1'b0, 1'b0});
    end else if (mw == 2'd3) begin
      if (mv[i] && mkey[i] == k) begin
        mv[i] = 1'b0;
        mocc--;
      end
    end else if (!mv[i]) begin
      mv[i] = 1'b1; mside[i] = int'(mw); mkey[i] = k; mopr[i] = o;
      mocc++;
    end else if (mkey[i] == k && mside[i] != int'(mw)) begin
      mv[i] = 1'b0;
      mocc--;
      exp_q.push_back({n, g, (mw == 2'd1) ? o : mopr[i], (mw == 2'd2) ? o : mopr[i], 1'b1, 1'b0});
    end else begin
      exp_q.push_back({n, g, o, 32'd0, 1'b0, 1'b1});
    end
  endfunction

  task automatic wait_idle_check_occ();
    int t = 0;
    @(negedge clk);
    while (!in_ack && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 128'(in_ack), 128'(1));
    check("occ", 128'(occ), 128'(mocc));
  endtask

  task automatic send(input logic [NODE_W-1:0] n, input logic [GEN_W-1:0] g,
                      input logic [OPR_W-1:0] o, input logic [1:0] mw,
                      input bit wait_idle, input bit lat);
    int t = 0;
    @(posedge clk); #1;
    in_send = 1'b1; node_i = n; gen_i = g; opr_i = o; mw_i = mw;
    @(negedge clk);
    while (!in_ack && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ack) begin
      check("accept_timeout", 128'(in_ack), 128'(1));
      in_send = 1'b0;
      return;
    end
    model_accept(n, g, o, mw);
    @(posedge clk); #1;
    in_send = 1'b0;
    if (lat) begin
      @(negedge clk);
      check("lat_look", 128'(out_send), 128'(0));
      @(negedge clk);
      check("lat_out", 128'(out_send), 128'(1));
    end
    if (wait_idle) wait_idle_check_occ();
  endtask

  task automatic wait_out_send();
    int t = 0;
    @(negedge clk);
    while (!out_send && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("out_send_timeout", 128'(out_send), 128'(1));
  endtask

  // Downstream ready: random when not stalled, changed just after each edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ack = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops one expected token per output transfer, and checks hold behaviour.
  initial begin
    tok_t got, prev, e;
    bit prev_hold;
    prev_hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      got = {node_o, gen_o, opr_l, opr_r, pair_o, ovf_o};
      if (!rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_send", 128'(out_send), 128'(1));
          check("hold_data", 128'(got), 128'(prev));
        end
        if (out_send) check("in_ack_during_out", 128'(in_ack), 128'(0));
        if (out_send && out_ack) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual=%0h required=none", got);
          end else begin
            e = exp_q.pop_front();
            check("out_tok", 128'(got), 128'(e));
            $display("out node=%0d gen=%0d l=%0h r=%0h pair=%0b ovf=%0b",
                     got.node, got.gen, got.l, got.r, got.pair, got.ovf);
          end
          prev_hold = 1'b0;
        end else begin
          prev_hold = out_send;
        end
        prev = got;
      end
    end
  end

  initial begin
    tok_t held;
    int t;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ack", 128'(in_ack), 128'(0));
    check("rst_out_send", 128'(out_send), 128'(0));
    check("rst_occ", 128'(occ), 128'(0));
    check("rst_opr_l", 128'(opr_l), 128'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("ack_after_rst", 128'(in_ack), 128'(1));

    // L then R pairs; R then L pairs order-independently
    send(16'd5, 12'd1, 32'hAAAA_0001, MW_L, 1'b1, 1'b0);
    send(16'd5, 12'd1, 32'hBBBB_0002, MW_R, 1'b1, 1'b1);
    send(16'd9, 12'd2, 32'hCCCC_0003, MW_R, 1'b1, 1'b0);
    send(16'd9, 12'd2, 32'hDDDD_0004, MW_L, 1'b1, 1'b0);
    // index collision (5^0 == 21^16) gives ovf, then purge the parked key
    send(16'd5, 12'd0, 32'hEEEE_0005, MW_L, 1'b1, 1'b0);
    send(16'd21, 12'd16, 32'hFFFF_0006, MW_L, 1'b1, 1'b0);
    send(16'd5, 12'd0, 32'h0, MW_PURGE, 1'b1, 1'b0);
    // same key, same side twice
    send(16'd3, 12'd0, 32'h1111_0007, MW_L, 1'b1, 1'b0);
    send(16'd3, 12'd0, 32'h2222_0008, MW_L, 1'b1, 1'b0);
    send(16'd3, 12'd0, 32'h0, MW_PURGE, 1'b1, 1'b0);

    // bypass under a 10-cycle downstream stall
    stall = 1'b1;
    send(16'd7, 12'd7, 32'h0000_DEAD, MW_BYP, 1'b0, 1'b0);
    wait_out_send();
    held = {node_o, gen_o, opr_l, opr_r, pair_o, ovf_o};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_data", 128'({node_o, gen_o, opr_l, opr_r, pair_o, ovf_o}), 128'(held));
      check("stall_in_ack", 128'(in_ack), 128'(0));
    end
    stall = 1'b0;
    wait_idle_check_occ();

    for (int i = 0; i < 300; i++) begin
      send(16'($urandom_range(0, 31)), 12'($urandom_range(0, 3)), $urandom,
           2'($urandom_range(0, 3)), 1'b1, 1'b0);
    end

    // reset in the middle of an output token
    send(16'd7, 12'd0, 32'h7777_0000, MW_L, 1'b1, 1'b0);
    stall = 1'b1;
    send(16'd2, 12'd0, 32'h2222_2222, MW_BYP, 1'b0, 1'b0);
    wait_out_send();
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_out_send", 128'(out_send), 128'(0));
    check("midrst_occ", 128'(occ), 128'(0));
    check("midrst_in_ack", 128'(in_ack), 128'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    stall = 1'b0;
    send(16'd7, 12'd0, 32'h7777_1111, MW_R, 1'b1, 1'b0);

    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    check("drain", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
